// File: rtl/acc_unit.sv
// Accumulator with a valid/ready handshake: LOAD/ADD/ADC/SUB into a registered
// accumulator with carry, zero and signed-overflow flags, one-cycle latency.
module acc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_ADC  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_ovf;
    logic             r_out_valid;
    logic [7:0]       r_op_count;

    op_e              w_op;
    logic             w_xfer;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_nxt_acc;
    logic             w_nxt_carry;
    logic             w_nxt_ovf;

    assign w_op     = op_e'(op);
    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // SUB reuses the adder as acc + ~operand + 1, so carry reads as no-borrow
    always_comb begin
        w_b         = operand;
        w_cin       = 1'b0;
        case (w_op)
            OP_LOAD: w_cin = 1'b0;
            OP_ADD:  w_cin = 1'b0;
            OP_ADC:  w_cin = r_carry;
            OP_SUB: begin
                w_b   = ~operand;
                w_cin = 1'b1;
            end
        endcase
        w_sum       = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
        w_nxt_acc   = w_sum[WIDTH-1:0];
        w_nxt_carry = w_sum[WIDTH];
        w_nxt_ovf   = (r_acc[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
        if (w_op == OP_LOAD) begin
            w_nxt_acc   = operand;
            w_nxt_carry = 1'b0;
            w_nxt_ovf   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_xfer) begin
                r_acc       <= w_nxt_acc;
                r_carry     <= w_nxt_carry;
                r_ovf       <= w_nxt_ovf;
                r_out_valid <= 1'b1;
                r_op_count  <= r_op_count + 8'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign acc       = r_acc;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = (r_acc == '0);
    assign out_valid = r_out_valid;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit: stimulus pushes hand-computed results,
// a negedge monitor pops one entry per consumed output and compares.
module tb_acc_unit;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] ADC  = 2'b10;
    localparam logic [1:0] SUB  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] operand;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic [7:0] op_count;

    acc_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       v;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc",      {24'd0, acc},      {24'd0, e.acc});
                check("carry",    {31'd0, carry},    {31'd0, e.c});
                check("zero",     {31'd0, zero},     {31'd0, e.z});
                check("ovf",      {31'd0, ovf},      {31'd0, e.v});
                check("op_count", {24'd0, op_count}, {24'd0, e.cnt});
            end
        end
    end

    task automatic push_exp(input logic [7:0] ea, input logic ec, input logic ev);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.acc = ea;
        e.c   = ec;
        e.z   = (ea == 8'h00);
        e.v   = ev;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // Drives one op for a single edge; caller guarantees in_ready will be high
    task automatic send(input logic [1:0] o, input logic [7:0] b,
                        input logic [7:0] ea, input logic ec, input logic ev);
        op       = o;
        operand  = b;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_send", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        push_exp(ea, ec, ev);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_acc",       {24'd0, acc},       32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_carry",     {31'd0, carry},     32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_op_count",  {24'd0, op_count},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with an op presented: it must be discarded and not counted
        rst = 1'b1; in_valid = 1'b1; op = LOAD; operand = 8'h55; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        check_reset_state();
        @(posedge clk); #1;

        send(LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0);
        send(ADD,  8'h01, 8'h80, 1'b0, 1'b1);
        send(LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send(ADD,  8'h01, 8'h00, 1'b1, 1'b0);
        send(ADC,  8'h00, 8'h01, 1'b0, 1'b0);
        send(LOAD, 8'h05, 8'h05, 1'b0, 1'b0);
        send(SUB,  8'h07, 8'hFE, 1'b0, 1'b0);
        send(LOAD, 8'h80, 8'h80, 1'b0, 1'b0);
        send(SUB,  8'h01, 8'h7F, 1'b1, 1'b1);
        send(ADC,  8'h10, 8'h90, 1'b0, 1'b1);
        send(LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0);
        send(ADD,  8'h20, 8'h10, 1'b1, 1'b0);
        send(ADC,  8'hF0, 8'h01, 1'b1, 1'b0);
        send(LOAD, 8'h33, 8'h33, 1'b0, 1'b0);
        send(SUB,  8'h33, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result must hold while the next op waits
        out_ready = 1'b0;
        send(LOAD, 8'h3C, 8'h3C, 1'b0, 1'b0);
        op = ADD; operand = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_acc",       {24'd0, acc},       32'h3C);
            check("hold_op_count",  {24'd0, op_count},  32'd16);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        push_exp(8'h3D, 1'b0, 1'b0);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("consume_xfer_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_cnt = 8'd0;
        check_reset_state();
        @(posedge clk); #1;

        // 256 back-to-back LOADs: op_count wraps, out_valid never drops
        in_valid = 1'b1; op = LOAD;
        for (int i = 0; i < 256; i++) begin
            operand = 8'(i);
            @(negedge clk);
            if (i > 0) check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            push_exp(8'(i), 1'b0, 1'b0);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("wrap_op_count",  {24'd0, op_count},  32'd0);
        check("wrap_out_valid", {31'd0, out_valid}, 32'd1);
        check("wrap_acc",       {24'd0, acc},       32'hFF);
        @(posedge clk); #1;

        // Reset collides with an ADD while a result is pending: both are dropped
        rst = 1'b1; in_valid = 1'b1; op = ADD; operand = 8'h01;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        exp_cnt = 8'd0;
        check_reset_state();
        @(posedge clk); #1;

        out_ready = 1'b1;
        send(LOAD, 8'h42, 8'h42, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, which sets the datapath width in bits.
REQ-002 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  is a synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 in_valid  input  1  SHALL mean the upstream op and operand are valid.
REQ-005 in_ready  output  1  SHALL mean the block accepts an op this cycle.
REQ-006 op  input  2  SHALL select the operation: 00 LOAD, 01 ADD, 10 ADC, 11 SUB.
REQ-007 operand  input  WIDTH  SHALL carry operand B.
REQ-008 out_valid  output  1  SHALL mean the result and flags are valid.
REQ-009 out_ready  input  1  SHALL mean downstream consumes the result this cycle.
REQ-010 acc  output  WIDTH  SHALL present the accumulator register value.
REQ-011 carry  output  1  SHALL present the carry flag; for SUB it means no-borrow.
REQ-012 zero  output  1  SHALL be high when acc is 0.
REQ-013 ovf  output  1  SHALL present the signed two's-complement overflow flag.
REQ-014 op_count  output  8  SHALL count accepted ops, wrapping modulo 256.

Function
REQ-015 in_ready SHALL equal (!out_valid || out_ready); it is combinational, with no dependence on in_valid.
REQ-016 An op transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-017 A transfer SHALL register its result into acc and the flags on that edge, giving one-cycle latency; out_valid SHALL be 1 the following cycle.
REQ-018 LOAD SHALL set acc=operand, carry=0, ovf=0.
REQ-019 ADD SHALL set {carry,acc}=acc+operand computed WIDTH+1 bits wide.
REQ-020 ADC SHALL set {carry,acc}=acc+operand+carry, using the carry value registered before this op.
REQ-021 SUB SHALL set {carry,acc}=acc+~operand+1, so carry=1 iff acc>=operand (unsigned).
REQ-022 For ADD and ADC, ovf SHALL be (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]); for SUB, b is ~operand; ovf SHALL be 0 for LOAD.
REQ-023 zero SHALL be derived from the registered acc, never from a separate stale flag.
REQ-024 acc, carry, ovf and zero SHALL hold their values when no transfer occurs.
REQ-025 out_valid SHALL clear when out_ready=1 and no transfer occurs in the same cycle.
REQ-026 On a simultaneous consume and transfer, out_valid SHALL stay 1 and the outputs SHALL update to the new result.
REQ-027 With out_valid=1 and out_ready=0, in_ready SHALL be 0, and outputs SHALL hold stable until consumed.
REQ-028 op_count SHALL increment by 1 per transfer, wrapping 255->0.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH, with carry capturing bit WIDTH.
REQ-030 op SHALL be fully decoded; no input combination SHALL produce an X.

Reset
REQ-031 While rst=1 at a rising edge, the block SHALL set acc=0, carry=0, ovf=0, op_count=0 and out_valid=0; zero SHALL then read 1.
REQ-032 rst SHALL take priority over a simultaneous transfer; an op presented in the reset cycle SHALL be discarded and not counted.
REQ-033 Reset asserted while out_valid=1 SHALL discard the pending result; in_ready SHALL be 1 in the cycle after reset.

Verification
REQ-034 Reset, then LOAD 0x7F, then ADD 0x01 -> acc=0x80, carry=0, ovf=1, zero=0, op_count=2.
REQ-035 LOAD 0xFF, ADD 0x01, then ADC 0x00 -> after ADD acc=0x00, carry=1, zero=1; after ADC acc=0x01, carry=0.
REQ-036 LOAD 0x05, then SUB 0x07 -> acc=0xFE, carry=0 (borrow), ovf=0; LOAD 0x80, SUB 0x01 -> acc=0x7F, carry=1, ovf=1.
REQ-037 Hold out_ready=0 after one op with in_valid=1 -> in_ready=0, acc stable for 5 cycles, op_count unchanged; raise out_ready with in_valid=1 -> consume and new transfer on the same edge, out_valid stays 1.
REQ-038 256 back-to-back LOAD ops with out_ready=1 -> op_count wraps to 0 and out_valid stays 1 on every cycle after the first.
REQ-039 Assert rst in the same cycle as an ADD while out_valid=1 -> next cycle out_valid=0, acc=0, zero=1, op_count=0, in_ready=1.
